// File: rtl/mem_map_pkg.sv
// Address map for the CPU memory responder: MMIO window placement,
// register offsets and the RAM/MMIO region decode.
package mem_map_pkg;

    localparam logic [15:0] MMIO_BASE_DEF = 16'hFF00;
    localparam logic [7:0]  MMIO_LED      = 8'h00;
    localparam logic [7:0]  MMIO_CNT      = 8'h02;

    typedef logic [15:0] addr_t;

    // Where the registered read data comes from on the following cycle.
    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_RAM,
        SRC_MMIO
    } rd_src_e;

    // Everything at or above the window base is I/O; below it is RAM.
    function automatic logic is_mmio(input addr_t a, input addr_t base);
        return a >= base;
    endfunction

endpackage

// File: rtl/ram_bytewide.sv
// 16-bit word RAM with per-byte write enables and a read-first
// synchronous read port, shaped to map onto a single block RAM.
module ram_bytewide #(
    parameter int DEPTH_W = 10
) (
    input  logic               clk,
    input  logic [1:0]         we_i,
    input  logic [DEPTH_W-1:0] waddr_i,
    input  logic [15:0]        wdata_i,
    input  logic [DEPTH_W-1:0] raddr_i,
    output logic [15:0]        rdata_o
);

    logic [15:0] mem_q [0:(1<<DEPTH_W)-1];
    logic [15:0] rdata_q;

    // Byte-lane writes and read-first registered read.
    always_ff @(posedge clk) begin
        if (we_i[0]) mem_q[waddr_i][7:0]  <= wdata_i[7:0];
        if (we_i[1]) mem_q[waddr_i][15:8] <= wdata_i[15:8];
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Far-end memory/bus responder: RAM with host preload, byte lanes,
// LED register, free-running cycle counter and misalignment flag.
module mem_responder
    import mem_map_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                DEPTH_W   = 10,
    parameter logic [ADDR_W-1:0] MMIO_BASE = ADDR_W'(MMIO_BASE_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  addr,
    input  logic               rd_mem,
    input  logic               wr_mem,
    input  logic               byt,
    input  logic [15:0]        wdata,
    output logic [15:0]        rdata,
    output logic               misalign,
    output logic [7:0]         led,
    input  logic               ld_en,
    input  logic [DEPTH_W-1:0] ld_addr,
    input  logic [15:0]        ld_data
);

    logic               mmio_sel;
    logic [ADDR_W-1:0]  mmio_rel;
    logic [7:0]         mmio_off;
    logic               in_win;
    logic               led_hit;
    logic               cnt_hit;
    logic               cpu_wr;

    logic [1:0]         ram_we;
    logic [DEPTH_W-1:0] ram_waddr;
    logic [15:0]        ram_wdata;
    logic [15:0]        ram_rdata;

    logic [15:0]        mmio_rd_d;
    logic [15:0]        mmio_rd_q;
    logic [7:0]         led_d;
    logic [7:0]         led_q;
    logic [15:0]        cnt_d;
    logic [15:0]        cnt_q;
    logic               mis_d;
    logic               mis_q;
    rd_src_e            src_d;
    rd_src_e            src_q;
    logic               byt_q;
    logic               lane_q;
    logic [15:0]        word_sel;

    assign mmio_sel = is_mmio(addr_t'(addr), addr_t'(MMIO_BASE));
    assign mmio_rel = addr - MMIO_BASE;
    assign mmio_off = mmio_rel[7:0];
    assign in_win   = (mmio_rel[ADDR_W-1:8] == '0);
    assign led_hit  = mmio_sel && in_win && (mmio_off == MMIO_LED);
    assign cnt_hit  = mmio_sel && in_win && (mmio_off == MMIO_CNT);
    assign cpu_wr   = wr_mem && !rst;

    // Preload owns the write port; otherwise CPU writes go to RAM by lane.
    always_comb begin
        ram_we    = 2'b00;
        ram_waddr = addr[DEPTH_W:1];
        ram_wdata = wdata;
        if (ld_en) begin
            ram_we    = 2'b11;
            ram_waddr = ld_addr;
            ram_wdata = ld_data;
        end else if (cpu_wr && !mmio_sel) begin
            if (byt) begin
                ram_we    = addr[0] ? 2'b10 : 2'b01;
                ram_wdata = {wdata[7:0], wdata[7:0]};
            end else begin
                ram_we    = 2'b11;
            end
        end
    end

    ram_bytewide #(
        .DEPTH_W (DEPTH_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (addr[DEPTH_W:1]),
        .rdata_o (ram_rdata)
    );

    // MMIO register next state and the pre-write read value.
    always_comb begin
        mmio_rd_d = 16'h0000;
        if (led_hit) mmio_rd_d = {8'h00, led_q};
        if (cnt_hit) mmio_rd_d = cnt_q + 16'd1;
        led_d = (cpu_wr && led_hit) ? wdata[7:0] : led_q;
        cnt_d = (cpu_wr && cnt_hit) ? 16'h0000 : cnt_q + 16'd1;
        mis_d = mis_q || (!byt && addr[0] && (rd_mem || wr_mem));
        src_d = mmio_sel ? SRC_MMIO : SRC_RAM;
    end

    // Read-side capture, I/O registers and the sticky flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q     <= SRC_ZERO;
            byt_q     <= 1'b0;
            lane_q    <= 1'b0;
            mmio_rd_q <= 16'h0000;
            led_q     <= 8'h00;
            cnt_q     <= 16'h0000;
            mis_q     <= 1'b0;
        end else begin
            src_q     <= src_d;
            byt_q     <= byt;
            lane_q    <= addr[0];
            mmio_rd_q <= mmio_rd_d;
            led_q     <= led_d;
            cnt_q     <= cnt_d;
            mis_q     <= mis_d;
        end
    end

    // Select the captured source and apply little-endian lane extraction.
    always_comb begin
        unique case (src_q)
            SRC_RAM:  word_sel = ram_rdata;
            SRC_MMIO: word_sel = mmio_rd_q;
            default:  word_sel = 16'h0000;
        endcase
        if (byt_q) begin
            rdata = {8'h00, lane_q ? word_sel[15:8] : word_sel[7:0]};
        end else begin
            rdata = word_sel;
        end
    end

    assign misalign = mis_q;
    assign led      = led_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed table from the test plan plus
// randomized traffic against a byte-array reference model.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic        rd_mem;
    logic        wr_mem;
    logic        byt;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        misalign;
    logic [7:0]  led;
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [15:0] ld_data;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_mem [0:2047];
    logic [7:0]  m_led;
    int          m_cnt;
    logic        m_mis;
    logic [15:0] m_rd;

    typedef struct {
        logic        rst;
        logic [15:0] addr;
        logic        rd;
        logic        wr;
        logic        byt;
        logic [15:0] wdata;
        logic        ld;
        logic [9:0]  ld_addr;
        logic [15:0] ld_data;
        logic        chk_rd;
        logic [15:0] exp_rd;
        logic [7:0]  exp_led;
        logic        exp_mis;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    mem_responder dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .rd_mem   (rd_mem),
        .wr_mem   (wr_mem),
        .byt      (byt),
        .wdata    (wdata),
        .rdata    (rdata),
        .misalign (misalign),
        .led      (led),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data)
    );

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour of one clock edge using the current inputs.
    task automatic model_step();
        logic [15:0] w;
        logic [10:0] bi;
        logic [10:0] lo;
        logic [10:0] hi;
        logic        mm;
        logic [7:0]  off;
        if (rst) begin
            m_rd  = 16'h0000;
            m_led = 8'h00;
            m_cnt = 0;
            m_mis = 1'b0;
            if (ld_en) begin
                m_mem[{ld_addr, 1'b0}] = ld_data[7:0];
                m_mem[{ld_addr, 1'b1}] = ld_data[15:8];
            end
            return;
        end
        mm  = (addr >= 16'hFF00);
        off = addr[7:0];
        bi  = addr[10:0];
        lo  = {bi[10:1], 1'b0};
        hi  = {bi[10:1], 1'b1};
        if (mm) begin
            if (off == 8'h00)      w = {8'h00, m_led};
            else if (off == 8'h02) w = 16'((m_cnt + 1) % 65536);
            else                   w = 16'h0000;
        end else begin
            w = {m_mem[hi], m_mem[lo]};
        end
        m_rd = byt ? {8'h00, (addr[0] ? w[15:8] : w[7:0])} : w;
        if (!byt && addr[0] && (rd_mem || wr_mem)) m_mis = 1'b1;
        if (mm && wr_mem && off == 8'h00) m_led = wdata[7:0];
        if (mm && wr_mem && off == 8'h02) m_cnt = 0;
        else                              m_cnt = (m_cnt + 1) % 65536;
        if (ld_en) begin
            m_mem[{ld_addr, 1'b0}] = ld_data[7:0];
            m_mem[{ld_addr, 1'b1}] = ld_data[15:8];
        end else if (wr_mem && !mm) begin
            if (byt) begin
                m_mem[bi] = wdata[7:0];
            end else begin
                m_mem[lo] = wdata[7:0];
                m_mem[hi] = wdata[15:8];
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("rdata", rdata, m_rd);
        check("misalign", {15'h0, misalign}, {15'h0, m_mis});
        check("led", {8'h00, led}, {8'h00, m_led});
    endtask

    function automatic vec_t mk(
        input logic r, input logic [15:0] a, input logic rd,
        input logic wr, input logic b, input logic [15:0] wd,
        input logic l, input logic [9:0] la, input logic [15:0] ldd,
        input logic c, input logic [15:0] er, input logic [7:0] el,
        input logic em);
        vec_t v;
        v.rst = r; v.addr = a; v.rd = rd; v.wr = wr; v.byt = b;
        v.wdata = wd; v.ld = l; v.ld_addr = la; v.ld_data = ldd;
        v.chk_rd = c; v.exp_rd = er; v.exp_led = el; v.exp_mis = em;
        return v;
    endfunction

    initial begin
        int r;
        rst = 1'b1; addr = '0; rd_mem = 0; wr_mem = 0; byt = 0;
        wdata = '0; ld_en = 0; ld_addr = '0; ld_data = '0;

        for (int i = 0; i < 1024; i++) begin
            ld_en   = 1'b1;
            ld_addr = 10'(i);
            ld_data = 16'($urandom);
            step();
        end
        ld_en = 1'b0;

        //            rst addr     rd wr byt wdata   ld la ldata    c  exp_rd   led    mis
        tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 16'h80A5, 1, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 16'h0000, 1, 1, 16'h0234, 1, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h80A5, 8'h00, 0));
        tbl.push_back(mk(0, 16'h0002, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0234, 8'h00, 0));
        tbl.push_back(mk(0, 16'h0010, 0, 1, 0, 16'h1234, 0, 0, 16'h0000, 0, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(0, 16'h0011, 0, 1, 1, 16'h00AB, 0, 0, 16'h0000, 1, 16'h0012, 8'h00, 0));
        tbl.push_back(mk(0, 16'h0010, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'hAB34, 8'h00, 0));
        tbl.push_back(mk(0, 16'h0010, 1, 0, 1, 16'h0000, 0, 0, 16'h0000, 1, 16'h0034, 8'h00, 0));
        tbl.push_back(mk(0, 16'h0021, 0, 1, 0, 16'hBEEF, 0, 0, 16'h0000, 0, 16'h0000, 8'h00, 1));
        tbl.push_back(mk(0, 16'h0020, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'hBEEF, 8'h00, 1));
        tbl.push_back(mk(0, 16'h000A, 0, 1, 0, 16'hAAAA, 1, 5, 16'h5555, 0, 16'h0000, 8'h00, 1));
        tbl.push_back(mk(0, 16'h000A, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h5555, 8'h00, 1));
        tbl.push_back(mk(0, 16'hFF00, 0, 1, 0, 16'h01C3, 0, 0, 16'h0000, 1, 16'h0000, 8'hC3, 1));
        tbl.push_back(mk(0, 16'hFF00, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h00C3, 8'hC3, 1));
        tbl.push_back(mk(0, 16'hFF02, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 8'hC3, 1));
        tbl.push_back(mk(0, 16'h0040, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 8'hC3, 1));
        tbl.push_back(mk(0, 16'h0040, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 8'hC3, 1));
        tbl.push_back(mk(0, 16'hFF02, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0003, 8'hC3, 1));
        tbl.push_back(mk(0, 16'hFF10, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 8'hC3, 1));
        tbl.push_back(mk(0, 16'h0030, 0, 1, 0, 16'h7777, 0, 0, 16'h0000, 0, 16'h0000, 8'hC3, 1));
        tbl.push_back(mk(1, 16'h0030, 0, 1, 0, 16'h1111, 0, 0, 16'h0000, 1, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(0, 16'hFF02, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0001, 8'h00, 0));
        tbl.push_back(mk(0, 16'h0030, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h7777, 8'h00, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; addr = tbl[i].addr; rd_mem = tbl[i].rd;
            wr_mem = tbl[i].wr; byt = tbl[i].byt; wdata = tbl[i].wdata;
            ld_en = tbl[i].ld; ld_addr = tbl[i].ld_addr;
            ld_data = tbl[i].ld_data;
            step();
            if (tbl[i].chk_rd) check($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rd);
            check($sformatf("tbl%0d_led", i), {8'h00, led}, {8'h00, tbl[i].exp_led});
            check($sformatf("tbl%0d_mis", i), {15'h0, misalign}, {15'h0, tbl[i].exp_mis});
        end

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            r = $urandom_range(0, 9);
            if (r < 6)       addr = 16'($urandom_range(0, 16'hFEFF));
            else if (r == 6) addr = 16'hFF00;
            else if (r == 7) addr = 16'hFF02;
            else if (r == 8) addr = 16'hFF00 | 16'($urandom_range(0, 255));
            else             addr = {5'($urandom), 11'($urandom_range(0, 63))};
            rd_mem  = 1'($urandom);
            wr_mem  = ($urandom_range(0, 2) == 0);
            byt     = 1'($urandom);
            wdata   = 16'($urandom);
            ld_en   = ($urandom_range(0, 15) == 0);
            ld_addr = 10'($urandom_range(0, 63));
            ld_data = 16'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory/bus responder at the far end of the CPU control-signal interface.
- Serves the CPU's instruction fetch (load_insn) and data accesses (rd_mem/wr_mem/byt) from a byte-addressed, word-organised RAM.
- Also provides a small memory-mapped I/O window: LED register and free-running cycle counter.
- Provides a host preload port that fills RAM with a program image while the CPU is held in reset.

Parameters:
- ADDR_W, 16, CPU byte-address width.
- DEPTH_W, 10, log2 of RAM depth in 16-bit words (1024 words = 2 KiB).
- MMIO_BASE, 16'hFF00, first byte address of the I/O window; window is MMIO_BASE..MMIO_BASE+0xFF.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- addr  in  16  byte address from ALU/IP mux; valid on every cycle.
- rd_mem  in  1  data read strobe (exec/rdmem phases).
- wr_mem  in  1  write strobe.
- byt  in  1  1 = byte access, 0 = word access.
- wdata  in  16  write data (stack top).
- rdata  out  16  registered read data.
- misalign  out  1  sticky flag: a word access used an odd address.
- led  out  8  LED register.
- ld_en  in  1  preload write enable.
- ld_addr  in  DEPTH_W  preload word address.
- ld_data  in  16  preload word.

Behaviour:
- Reset values (rst=1 at posedge): rdata=0, misalign=0, led=0, counter=0. RAM contents are not reset.
- While rst=1, CPU writes are ignored. ld_en is honoured during reset.
- Read path: synchronous, latency 1.
  - At every posedge, a read of addr is captured and presented on rdata the following cycle, regardless of rd_mem. This makes fetch data ready when load_insn samples it.
  - rd_mem only qualifies read side effects; there are none in this revision, but the port is kept.
  - Word read: RAM word at addr[DEPTH_W:1]. Little-endian: even byte in [7:0], odd byte in [15:8].
  - Byte read (byt=1 registered with addr): rdata = {8'h00, selected lane}, where lane = registered addr[0].
- RAM aliasing: RAM occupies all addresses below MMIO_BASE. Address bits above DEPTH_W+1 are ignored (aliases).
- Write path, at posedge when wr_mem=1 and rst=0:
  - byt=1: write wdata[7:0] into lane addr[0] only; the other lane is unchanged.
  - byt=0: write the full word at addr[DEPTH_W:1]. If addr[0]=1, the write still occurs with bit 0 ignored, and misalign is set.
- misalign: set by any word read or write with odd addr when rd_mem or wr_mem is 1. It is cleared only by rst.
- Preload priority: when ld_en=1, write ld_data to word ld_addr. A CPU wr_mem to RAM in the same cycle is dropped. MMIO writes are unaffected by ld_en.
- Read-during-write, same word: rdata returns the old contents (read-first).
- MMIO (addr >= MMIO_BASE):
  - Offset 0x00, LED: a write loads led <= wdata[7:0] (byte or word access). Read returns {8'h00, led}.
  - Offset 0x02, COUNTER:
    - 16-bit counter increments every cycle when rst=0 and wraps 0xFFFF -> 0x0000.
    - Read returns the counter value at the sampling edge.
    - Any write clears it to 0 on that edge. The next cycle it reads 1 if sampled one cycle later.
  - Other offsets: reads return 0; writes are ignored; no RAM access.
  - MMIO accesses never touch RAM.
- A simultaneous read and write to LED in one cycle returns the pre-write value.

Decomposition:
- Package mem_map_pkg holds:
  - MMIO_BASE default;
  - offsets MMIO_LED=8'h00 and MMIO_CNT=8'h02;
  - a region-decode function is_mmio(addr).
- Sub-module ram_bytewide (DEPTH_W parameter): one synchronous read port plus one write port with two byte enables, read-first. It is a single inferred BRAM.
- mem_responder contains the address decode, lane muxing, MMIO registers, counter and preload arbitration.

Test Plan:
- Preload: rst=1, ld_en writes 0x80A5 at word 0 and 0x0234 at word 1. Then rst=0 with addr=0, then addr=2 → rdata=0x80A5, then 0x0234, each one cycle after the address.
- Byte write/read: word write 0x1234 at 0x0010; byte write 0xAB at 0x0011; word read 0x0010 → 0xAB34. Byte read 0x0010 → 0x0034.
- Misaligned word: wr_mem with byt=0, addr=0x0021, wdata=0xBEEF → misalign=1 next cycle, word 0x0020 = 0xBEEF. misalign stays 1 until rst.
- Collision: ld_en=1 (ld_addr=5, 0x5555) in the same cycle as CPU wr_mem to 0x000A with 0xAAAA → word 5 reads 0x5555.
- MMIO: write 0x01C3 to 0xFF00 → led=0xC3, read → 0x00C3. Write to 0xFF02 then read 3 cycles later → rdata=0x0003 (±per counter timing above, bench checks exact value). Read 0xFF10 → 0x0000.
- Reset mid-operation: assert rst with wr_mem=1 to 0x0030 → word unchanged, rdata=0, led=0, counter=0 on the following cycle.
